// File: rtl/threshold_stream.sv
// Raster fetch of RGB pixel pairs, global binary threshold, 2-cycle output pipeline.
// Optional build macro THRESHOLD_INVERT_EN inverts the threshold polarity.
module threshold_stream #(
    parameter int IMAGE_WIDTH  = 768,
    parameter int IMAGE_HEIGHT = 512,
    parameter int START_DELAY  = 100,
    parameter int HSYNC_DELAY  = 160,
    parameter int ADDR_WIDTH   = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            threshold_value,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [23:0]           rd_data_even,
    input  logic [23:0]           rd_data_odd,
    output logic                  horizontal_Pulse,
    output logic [7:0]            data_Red_Even,
    output logic [7:0]            data_Green_Even,
    output logic [7:0]            data_Blue_Even,
    output logic [7:0]            data_Red_Odd,
    output logic [7:0]            data_Green_Odd,
    output logic [7:0]            data_Blue_Odd,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int HALF = IMAGE_WIDTH / 2;
    localparam int DMAX = (START_DELAY > HSYNC_DELAY) ? START_DELAY : HSYNC_DELAY;
    localparam int CW   = $clog2(HALF + 1);
    localparam int RW   = $clog2(IMAGE_HEIGHT + 1);
    localparam int DW   = $clog2(DMAX + 3);

`ifdef THRESHOLD_INVERT_EN
    localparam logic INVERT = 1'b1;
`else
    localparam logic INVERT = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, START_WAIT, LINE, GAP, FLUSH} state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [DW-1:0] dly;
    logic [7:0]    t_reg;
    logic          pulse_d1;

    // rd_addr is kept as a running pair counter; it equals row*HALF+col because
    // it advances only in LINE and GAP leaves it untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            dly        <= '0;
            t_reg      <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        t_reg <= threshold_value;
                        busy  <= 1'b1;
                        dly   <= '0;
                        state <= START_WAIT;
                    end
                end
                START_WAIT: begin
                    if (dly == DW'(START_DELAY - 1)) begin
                        dly     <= '0;
                        row     <= '0;
                        col     <= '0;
                        rd_addr <= '0;
                        rd_en   <= 1'b1;
                        state   <= LINE;
                    end else begin
                        dly <= dly + 1'b1;
                    end
                end
                LINE: begin
                    rd_addr <= rd_addr + 1'b1;
                    if (col == CW'(HALF - 1)) begin
                        col   <= '0;
                        row   <= row + 1'b1;
                        rd_en <= 1'b0;
                        state <= (row == RW'(IMAGE_HEIGHT - 1)) ? FLUSH : GAP;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                GAP: begin
                    if (dly == DW'(HSYNC_DELAY - 1)) begin
                        dly   <= '0;
                        rd_en <= 1'b1;
                        state <= LINE;
                    end else begin
                        dly <= dly + 1'b1;
                    end
                end
                FLUSH: begin
                    // Two drain cycles, then frame_done is high for one cycle while still in FLUSH.
                    dly <= dly + 1'b1;
                    if (dly == DW'(1)) frame_done <= 1'b1;
                    if (dly == DW'(2)) begin
                        dly   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    function automatic logic [7:0] binarize(input logic [23:0] px, input logic [7:0] t);
        logic [9:0] sum;
        logic [9:0] t3;
        sum = {2'b00, px[23:16]} + {2'b00, px[15:8]} + {2'b00, px[7:0]};
        t3  = {2'b00, t} + {1'b0, t, 1'b0};
        return ((sum > t3) ^ INVERT) ? 8'hFF : 8'h00;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pulse_d1         <= 1'b0;
            horizontal_Pulse <= 1'b0;
            data_Red_Even    <= '0;
            data_Green_Even  <= '0;
            data_Blue_Even   <= '0;
            data_Red_Odd     <= '0;
            data_Green_Odd   <= '0;
            data_Blue_Odd    <= '0;
        end else begin
            pulse_d1         <= rd_en;
            horizontal_Pulse <= pulse_d1;
            if (pulse_d1) begin
                data_Red_Even   <= binarize(rd_data_even, t_reg);
                data_Green_Even <= binarize(rd_data_even, t_reg);
                data_Blue_Even  <= binarize(rd_data_even, t_reg);
                data_Red_Odd    <= binarize(rd_data_odd, t_reg);
                data_Green_Odd  <= binarize(rd_data_odd, t_reg);
                data_Blue_Odd   <= binarize(rd_data_odd, t_reg);
            end
        end
    end

endmodule

// File: tb/tb_threshold_stream.sv
// Scoreboard bench for threshold_stream on a small 8x2 frame; timing from frame arithmetic.
module tb_threshold_stream;

    localparam int W    = 8;
    localparam int H    = 2;
    localparam int SD   = 4;
    localparam int HS   = 3;
    localparam int AW   = 4;
    localparam int HALF = W / 2;
    localparam int NP   = W * H / 2;
    localparam int PER  = HALF + HS;
    localparam int LAST_RD = SD + 1 + (H - 1) * PER + HALF - 1;
    localparam int DONE    = LAST_RD + 3;
    localparam int GAP_OFF   = SD + 1 + HALF + 1;
    localparam int ABORT_OFF = SD + 1 + PER + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    threshold_value;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [23:0]   rd_data_even;
    logic [23:0]   rd_data_odd;
    logic          horizontal_Pulse;
    logic [7:0]    data_Red_Even, data_Green_Even, data_Blue_Even;
    logic [7:0]    data_Red_Odd, data_Green_Odd, data_Blue_Odd;
    logic          busy;
    logic          frame_done;

    threshold_stream #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .START_DELAY(SD),
        .HSYNC_DELAY(HS), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .threshold_value(threshold_value),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data_even(rd_data_even), .rd_data_odd(rd_data_odd),
        .horizontal_Pulse(horizontal_Pulse),
        .data_Red_Even(data_Red_Even), .data_Green_Even(data_Green_Even),
        .data_Blue_Even(data_Blue_Even), .data_Red_Odd(data_Red_Odd),
        .data_Green_Odd(data_Green_Odd), .data_Blue_Odd(data_Blue_Odd),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          s_cyc = 0;
    bit          s_active = 1'b0;
    logic [23:0] mem_e [NP];
    logic [23:0] mem_o [NP];
    logic [47:0] exp_q [$];
    logic [47:0] last_out = '0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic logic [23:0] thr(input logic [23:0] px, input logic [7:0] t);
        int s;
        bit hi;
        s  = int'(px[23:16]) + int'(px[15:8]) + int'(px[7:0]);
        hi = (s > 3 * int'(t));
`ifdef THRESHOLD_INVERT_EN
        hi = !hi;
`endif
        return hi ? 24'hFFFFFF : 24'h000000;
    endfunction

    function automatic logic [23:0] near_px(input logic [7:0] t);
        int b;
        if ($urandom_range(0, 1) == 0) return 24'($urandom);
        b = int'(t) + int'($urandom_range(0, 2)) - 1;
        if (b < 0) b = 0;
        if (b > 255) b = 255;
        return {t, t, 8'(b)};
    endfunction

    task automatic fill(input logic [7:0] t);
        for (int p = 0; p < NP; p++) begin
            mem_e[p] = near_px(t);
            mem_o[p] = near_px(t);
        end
    endtask

    // Memory model: data for the address seen with rd_en appears in the following cycle.
    initial begin
        logic          pend;
        logic [AW-1:0] a;
        forever begin
            @(negedge clk);
            pend = rd_en;
            a    = rd_addr;
            @(posedge clk);
            #1;
            if (pend && int'(a) < NP) begin
                rd_data_even = mem_e[a];
                rd_data_odd  = mem_o[a];
            end else begin
                rd_data_even = 24'($urandom);
                rd_data_odd  = 24'($urandom);
            end
        end
    end

    // Monitor: timing from frame offsets, data popped from the scoreboard on each pulse.
    initial begin
        int          off, k;
        bit          e_rd, e_pl;
        logic [47:0] act, expv;
        forever begin
            @(negedge clk);
            off  = s_active ? (cyc - s_cyc) : -1000;
            k    = off - SD - 1;
            e_rd = (off >= SD + 1) && (off <= LAST_RD) && ((k % PER) < HALF);
            e_pl = (off >= SD + 3) && (off <= LAST_RD + 2) && (((k - 2) % PER) < HALF);
            chk("rd_en", 48'(rd_en), 48'(e_rd));
            if (e_rd && rd_en) chk("rd_addr", 48'(rd_addr), 48'((k / PER) * HALF + (k % PER)));
            chk("horizontal_Pulse", 48'(horizontal_Pulse), 48'(e_pl));
            chk("busy", 48'(busy), 48'((off >= 1) && (off <= DONE)));
            chk("frame_done", 48'(frame_done), 48'(off == DONE));
            act = {data_Red_Even, data_Green_Even, data_Blue_Even,
                   data_Red_Odd, data_Green_Odd, data_Blue_Odd};
            if (horizontal_Pulse) begin
                if (exp_q.size() == 0) begin
                    chk("pulse_without_expected_pair", 48'(1), 48'(0));
                end else begin
                    expv = exp_q.pop_front();
                    chk("pixel_pair", act, expv);
                    last_out = expv;
                end
            end else begin
                chk("held_data", act, last_out);
            end
        end
    end

    // mode 0: plain frame; 1: start re-pulsed in START_WAIT, GAP and on frame_done; 2: reset mid-LINE
    task automatic run_frame(input logic [7:0] t, input int mode);
        start           = 1'b1;
        threshold_value = t;
        s_cyc           = cyc;
        s_active        = 1'b1;
        for (int p = 0; p < NP; p++) exp_q.push_back({thr(mem_e[p], t), thr(mem_o[p], t)});
        tick;
        for (int o = 1; o <= DONE + 3; o++) begin
            threshold_value = 8'($urandom);
            start = (mode == 1) && (o == 2 || o == GAP_OFF || o == DONE);
            if (mode == 2 && o == ABORT_OFF) begin
                start    = 1'b0;
                reset    = 1'b0;
                s_active = 1'b0;
                exp_q.delete();
                last_out = '0;
                tick;
                tick;
                reset = 1'b1;
                repeat (4) tick;
                return;
            end
            tick;
        end
        start = 1'b0;
    endtask

    initial begin
        reset           = 1'b0;
        start           = 1'b0;
        threshold_value = '0;
        rd_data_even    = '0;
        rd_data_odd     = '0;
        repeat (3) tick;
        reset = 1'b1;
        repeat (2) tick;

        fill(8'd100);
        mem_e[0] = {8'd100, 8'd100, 8'd100};
        mem_o[0] = {8'd101, 8'd100, 8'd100};
        run_frame(8'd100, 0);

        fill(8'd255);
        for (int p = 0; p < NP; p++) mem_e[p] = 24'hFFFFFF;
        mem_o[1] = {8'd255, 8'd255, 8'd254};
        run_frame(8'd255, 0);

        fill(8'd0);
        mem_e[0] = {8'd0, 8'd0, 8'd1};
        mem_o[0] = 24'h000000;
        run_frame(8'd0, 0);

        fill(8'd60);
        run_frame(8'd60, 1);
        repeat (3) tick;

        fill(8'd140);
        run_frame(8'd140, 2);

        fill(8'd30);
        run_frame(8'd30, 0);

        for (int f = 0; f < 8; f++) begin
            logic [7:0] t;
            t = 8'($urandom);
            fill(t);
            run_frame(t, 0);
            repeat ($urandom_range(0, 3)) tick;
        end

        repeat (4) tick;
        chk("scoreboard_drained", 48'(exp_q.size()), 48'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
